par_frame_tx: RTL and testbench

Serial frame transmitter placed directly downstream of the 4-bit even-parity generator. It accepts a data nibble plus its generated parity bit over a valid/ready handshake. It then serializes them onto a single line as start bit, data bits LSB first, parity bit, stop bit. Each bit is held for a fixed number of clock cycles. This is the link stage between parity generation and the serial channel.

---
 rtl/par_frame_tx_pkg.sv | 22 ++
 rtl/par_frame_tx_bit_timer.sv | 31 +++
 rtl/par_frame_tx.sv | 98 +++++++++
 tb/tb_par_frame_tx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/par_frame_tx_pkg.sv
// Shared types and line levels for the parity frame transmitter.
// Imported by the transmitter and its bit timer.
package par_frame_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  // Counter width that never collapses to zero bits.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/par_frame_tx_bit_timer.sv
// End-of-bit tick generator for the frame transmitter.
// Counts 0..CLKS_PER_BIT-1, wraps on tick, held at 0 by clr.
module bit_timer
  import par_frame_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = min1_clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/par_frame_tx.sv
// Serial frame transmitter: start, data LSB first, parity, stop.
// Sits directly after the even-parity generator.
module par_frame_tx
  import par_frame_tx_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              par_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int IW = min1_clog2(DATA_W);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] shreg;
  logic              par_q;
  logic [IW-1:0]     idx;
  logic              tick;
  logic              timer_clr;
  logic              accept;
  logic              last_bit;

  // Timer sits at 0 while idle; all other state changes
  // land on a tick, where it wraps to 0 anyway.
  assign timer_clr = (state == IDLE);
  assign accept    = in_valid && (state == IDLE);
  assign last_bit  = (idx == LAST_IDX);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (timer_clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = START;
      START:   if (tick) state_nxt = DATA;
      DATA:    if (tick && last_bit) state_nxt = PARITY;
      PARITY:  if (tick) state_nxt = STOP;
      STOP:    if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      par_q <= 1'b0;
      idx   <= '0;
    end else if (accept) begin
      shreg <= data_in;
      par_q <= par_in;
      idx   <= '0;
    end else if (state == DATA && tick) begin
      shreg <= shreg >> 1;
      idx   <= last_bit ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    tx = IDLE_LVL;
    unique case (state)
      START:   tx = START_LVL;
      DATA:    tx = shreg[0];
      PARITY:  tx = par_q;
      STOP:    tx = STOP_LVL;
      default: tx = IDLE_LVL;
    endcase
  end

  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign frame_done = (state == STOP) && tick;

endmodule

// File: tb/tb_par_frame_tx.sv
// Directed bench for par_frame_tx, default and one-clock-per-bit builds.
// Samples on falling edges, drives just after them.
module tb_par_frame_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] data_in;
  logic       par_in;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic       frame_done;

  logic [3:0] data_in1;
  logic       par_in1;
  logic       in_valid1;
  logic       in_ready1;
  logic       tx1;
  logic       busy1;
  logic       frame_done1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  par_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .par_in    (par_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  par_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in1),
    .par_in    (par_in1),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .tx        (tx1),
    .busy      (busy1),
    .frame_done(frame_done1)
  );

  // Frame bits in send order: [0]=start .. [6]=stop.
  function automatic logic [6:0] frame_bits(input logic [3:0] d,
                                            input logic p);
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if ({tx, busy, in_ready, frame_done} !== 4'b1010) begin
        errors++;
        $display("FAIL reset_hold tx/busy/rdy/done=%b want 1010",
                 {tx, busy, in_ready, frame_done});
      end
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      checks++;
      if ({tx, busy, in_ready, frame_done} !== 4'b1010 ||
          {tx1, busy1, in_ready1, frame_done1} !== 4'b1010) begin
        errors++;
        $display("FAIL reset_idle dut=%b dut1=%b want 1010",
                 {tx, busy, in_ready, frame_done},
                 {tx1, busy1, in_ready1, frame_done1});
      end
    end
  endtask

  task automatic test_basic(input string name, input logic [3:0] d,
                            input logic p);
    logic [6:0] bits;
    logic       exp_tx;
    bits = frame_bits(d, p);
    @(negedge clk);
    data_in  = d;
    par_in   = p;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    data_in  = 4'hF;
    par_in   = ~p;
    for (int k = 1; k <= 28; k++) begin
      exp_tx = bits[(k - 1) / 4];
      checks++;
      if (tx !== exp_tx || frame_done !== (k == 28) ||
          busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s cyc%0d tx=%b done=%b busy=%b rdy=%b want %b %b 1 0",
                 name, k, tx, frame_done, busy, in_ready, exp_tx, k == 28);
      end
      @(negedge clk);
    end
    checks++;
    if ({tx, busy, in_ready, frame_done} !== 4'b1010) begin
      errors++;
      $display("FAIL %s after tx/busy/rdy/done=%b want 1010",
               name, {tx, busy, in_ready, frame_done});
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] bits;
    logic       exp_tx;
    @(negedge clk);
    data_in  = 4'hA;
    par_in   = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    data_in  = 4'h5;
    par_in   = 1'b0;
    bits = frame_bits(4'hA, 1'b0);
    for (int k = 1; k <= 28; k++) begin
      exp_tx = bits[(k - 1) / 4];
      checks++;
      if (tx !== exp_tx || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_first cyc%0d tx=%b rdy=%b want %b 0",
                 k, tx, in_ready, exp_tx);
      end
      @(negedge clk);
    end
    checks++;
    if (in_ready !== 1'b1 || tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap rdy=%b tx=%b busy=%b want 1 1 0",
               in_ready, tx, busy);
    end
    @(negedge clk);
    in_valid = 1'b0;
    bits = frame_bits(4'h5, 1'b0);
    for (int k = 1; k <= 28; k++) begin
      exp_tx = bits[(k - 1) / 4];
      checks++;
      if (tx !== exp_tx || busy !== 1'b1 || frame_done !== (k == 28)) begin
        errors++;
        $display("FAIL b2b_second cyc%0d tx=%b busy=%b done=%b want %b 1 %b",
                 k, tx, busy, frame_done, exp_tx, k == 28);
      end
      @(negedge clk);
    end
    repeat (3) begin
      checks++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
        errors++;
        $display("FAIL b2b_idle busy=%b tx=%b want 0 1", busy, tx);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    data_in  = 4'h6;
    par_in   = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || tx !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre busy=%b tx=%b want 1 0", busy, tx);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx, busy, in_ready, frame_done} !== 4'b1010) begin
      errors++;
      $display("FAIL mid_async tx/busy/rdy/done=%b want 1010",
               {tx, busy, in_ready, frame_done});
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b0 || tx !== 1'b1) begin
        errors++;
        $display("FAIL mid_hold done=%b tx=%b want 0 1", frame_done, tx);
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_basic("mid_after", 4'h3, 1'b0);
  endtask

  task automatic test_clk1();
    logic [6:0] bits;
    bits = frame_bits(4'b0110, 1'b0);
    @(negedge clk);
    data_in1  = 4'b0110;
    par_in1   = 1'b0;
    in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      checks++;
      if (tx1 !== bits[k - 1] || frame_done1 !== (k == 7) ||
          busy1 !== 1'b1) begin
        errors++;
        $display("FAIL clk1 cyc%0d tx=%b done=%b busy=%b want %b %b 1",
                 k, tx1, frame_done1, busy1, bits[k - 1], k == 7);
      end
      @(negedge clk);
    end
    checks++;
    if (in_ready1 !== 1'b1 || tx1 !== 1'b1 || frame_done1 !== 1'b0) begin
      errors++;
      $display("FAIL clk1_after rdy=%b tx=%b done=%b want 1 1 0",
               in_ready1, tx1, frame_done1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    data_in   = 4'h0;
    par_in    = 1'b0;
    in_valid  = 1'b0;
    data_in1  = 4'h0;
    par_in1   = 1'b0;
    in_valid1 = 1'b0;
    test_reset();
    test_basic("basic", 4'b1011, 1'b1);
    test_basic("verbatim_par", 4'b0000, 1'b1);
    test_back_to_back();
    test_reset_mid();
    test_clk1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
